// File: rtl/imem_program_loader.sv
// Instruction-memory loader: parses a 16-bit word-count header, packs big-endian bytes
// into 32-bit words and writes them from BASE_ADDR up. Optional trailer check: CHECKSUM_EN.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_WORDS = 1024,
  parameter int          CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             len_err,
  output logic             chk_err,
  output logic [CNT_W-1:0] words_written
);

  localparam logic [31:0]      MAX_W32 = 32'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_LOAD   = 3'd3,
`ifdef CHECKSUM_EN
    S_CHK    = 3'd4,
`endif
    S_DONE   = 3'd5
  } state_t;

  state_t           state_r, state_nx;
  logic [CNT_W-1:0] cnt_r, cnt_nx;
  logic [1:0]       idx_r, idx_nx;
  logic [23:0]      shift_r, shift_nx;
  logic [CNT_W-1:0] words_nx;
  // pend_r marks the settle cycle after the header or the final word, with in_ready low
  logic             pend_r, pend_nx;
  logic             we_nx, run_s, accept_s;
  logic [31:0]      addr_nx, wdata_nx;
  logic             len_err_nx, in_ready_nx, busy_nx, done_nx;
`ifdef CHECKSUM_EN
  logic [7:0]       xor_r, xor_nx;
  logic             chk_err_r, chk_err_nx;
`endif

  assign accept_s = in_valid & in_ready;

  // Next-state and next-output logic; all outputs are registered from these values
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    idx_nx     = idx_r;
    shift_nx   = shift_r;
    words_nx   = words_written;
    pend_nx    = pend_r;
    we_nx      = 1'b0;
    addr_nx    = imem_addr;
    wdata_nx   = imem_wdata;
    len_err_nx = len_err;
`ifdef CHECKSUM_EN
    xor_nx     = xor_r;
    chk_err_nx = chk_err_r;
`endif
    case (state_r)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx   = S_LEN_HI;
          len_err_nx = 1'b0;
          words_nx   = '0;
          idx_nx     = 2'd0;
          pend_nx    = 1'b0;
`ifdef CHECKSUM_EN
          xor_nx     = 8'd0;
          chk_err_nx = 1'b0;
`endif
        end else begin
          state_nx = state_r;
        end
      end
      S_LEN_HI: begin
        if (accept_s) begin
          cnt_nx   = {in_data, cnt_r[7:0]};
          state_nx = S_LEN_LO;
        end else begin
          state_nx = state_r;
        end
      end
      S_LEN_LO: begin
        if (pend_r) begin
          pend_nx = 1'b0;
          if (cnt_r == '0) begin
            state_nx = S_DONE;
          end else if (32'(cnt_r) > MAX_W32) begin
            len_err_nx = 1'b1;
            state_nx   = S_DONE;
          end else begin
            state_nx = S_LOAD;
          end
        end else if (accept_s) begin
          cnt_nx  = {cnt_r[15:8], in_data};
          pend_nx = 1'b1;
        end else begin
          state_nx = state_r;
        end
      end
      S_LOAD: begin
        if (pend_r) begin
          pend_nx = 1'b0;
`ifdef CHECKSUM_EN
          state_nx = S_CHK;
`else
          state_nx = S_DONE;
`endif
        end else if (accept_s) begin
`ifdef CHECKSUM_EN
          xor_nx = xor_r ^ in_data;
`endif
          if (idx_r == 2'd3) begin
            we_nx    = 1'b1;
            addr_nx  = BASE_ADDR + 32'(words_written);
            wdata_nx = {shift_r, in_data};
            words_nx = words_written + CNT_ONE;
            idx_nx   = 2'd0;
            if ((words_written + CNT_ONE) == cnt_r) begin
              pend_nx = 1'b1;
            end else begin
              pend_nx = 1'b0;
            end
          end else begin
            shift_nx = {shift_r[15:0], in_data};
            idx_nx   = idx_r + 2'd1;
          end
        end else begin
          state_nx = state_r;
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (accept_s) begin
          chk_err_nx = (in_data != xor_r);
          state_nx   = S_DONE;
        end else begin
          state_nx = state_r;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    run_s       = (state_nx != S_IDLE) && (state_nx != S_DONE);
    in_ready_nx = run_s & ~pend_nx;
    busy_nx     = run_s;
    done_nx     = (state_nx == S_DONE);
  end

  // State and registered outputs with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      idx_r         <= 2'd0;
      shift_r       <= 24'd0;
      pend_r        <= 1'b0;
      words_written <= '0;
      imem_we       <= 1'b0;
      imem_addr     <= BASE_ADDR;
      imem_wdata    <= 32'd0;
      len_err       <= 1'b0;
      in_ready      <= 1'b0;
      busy          <= 1'b0;
      core_hold     <= 1'b0;
      done          <= 1'b0;
`ifdef CHECKSUM_EN
      xor_r         <= 8'd0;
      chk_err_r     <= 1'b0;
`endif
    end else begin
      state_r       <= state_nx;
      cnt_r         <= cnt_nx;
      idx_r         <= idx_nx;
      shift_r       <= shift_nx;
      pend_r        <= pend_nx;
      words_written <= words_nx;
      imem_we       <= we_nx;
      imem_addr     <= addr_nx;
      imem_wdata    <= wdata_nx;
      len_err       <= len_err_nx;
      in_ready      <= in_ready_nx;
      busy          <= busy_nx;
      core_hold     <= busy_nx;
      done          <= done_nx;
`ifdef CHECKSUM_EN
      xor_r         <= xor_nx;
      chk_err_r     <= chk_err_nx;
`endif
    end
  end

`ifdef CHECKSUM_EN
  assign chk_err = chk_err_r;
`else
  assign chk_err = 1'b0;
`endif

endmodule
